// File: rtl/mem_rd_ctrl_pkg.sv
// mem_rd_ctrl_pkg
// Shared constants and the state encoding for the memory-read sequencer.
//   MEM_RD_STATE_WIDTH : width of the sequencer state register
//   MEM_ADDR_W         : external address bus width
//   MEM_DATA_W         : external data bus width
//   mem_rd_state_e     : IDLE, T1, T2, TW (wait), T3
package mem_rd_ctrl_pkg;

  localparam int MEM_RD_STATE_WIDTH = 3;
  localparam int MEM_ADDR_W         = 16;
  localparam int MEM_DATA_W         = 8;

  typedef enum logic [MEM_RD_STATE_WIDTH-1:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } mem_rd_state_e;

  // Every non-idle state has the memory strobes asserted.
  function automatic logic bus_active(input mem_rd_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mem_rd_ctrl.sv
// mem_rd_ctrl
// Z80-style memory-read sequencer. On rd_start (accepted only in IDLE) it
// runs T1/T2/[TW...]/T3 machine cycles, one for a byte read or two for a
// little-endian word read, and captures the data bus into reg_mem_din.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | strobes high, addr_out holds, waits for rd_start
// T1    | address presented, mreq_n/rd_n low
// T2    | wait_n sampled: low -> TW, high -> T3
// TW    | wait state, repeats while wait_n low
// T3    | data_in captured; second byte of a word -> T1, else -> IDLE
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   rd_start    in   read request strobe (IDLE only)
//   rd_word     in   1 = two-byte read, sampled with rd_start
//   rd_addr     in   start address, sampled with rd_start
//   wait_n      in   memory wait request, active low
//   data_in     in   external data bus
//   addr_out    out  external address bus (registered)
//   mreq_n      out  memory request, active low (registered)
//   rd_n        out  read strobe, active low (registered)
//   reg_mem_din out  captured data, [7:0] first byte, [15:8] second byte
//   busy        out  transfer in progress
//   done        out  one-cycle pulse, reg_mem_din valid
module mem_rd_ctrl
  import mem_rd_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_start,
  input  logic                    rd_word,
  input  logic [MEM_ADDR_W-1:0]   rd_addr,
  input  logic                    wait_n,
  input  logic [MEM_DATA_W-1:0]   data_in,
  output logic [MEM_ADDR_W-1:0]   addr_out,
  output logic                    mreq_n,
  output logic                    rd_n,
  output logic [2*MEM_DATA_W-1:0] reg_mem_din,
  output logic                    busy,
  output logic                    done
);

  mem_rd_state_e           state_q, state_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic                    word_q, word_d;
  logic                    second_q, second_d;
  logic [2*MEM_DATA_W-1:0] din_q, din_d;
  logic                    strobe_n_q, strobe_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_q     <= 1'b0;
      second_q   <= 1'b0;
      din_q      <= '0;
      strobe_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      second_q   <= second_d;
      din_q      <= din_d;
      strobe_n_q <= strobe_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    second_d = second_q;
    din_d    = din_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          addr_d   = rd_addr;
          word_d   = rd_word;
          second_d = 1'b0;
          state_d  = ST_T1;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = wait_n ? ST_T3 : ST_TW;
      ST_TW: begin
        if (wait_n) state_d = ST_T3;
      end
      ST_T3: begin
        if (second_q) din_d[15:8] = data_in;
        else          din_d[7:0]  = data_in;
        if (word_q && !second_q) begin
          // Going straight back to T1 keeps the strobes low between bytes.
          addr_d   = addr_q + 16'd1;
          second_d = 1'b1;
          state_d  = ST_T1;
        end else begin
          second_d = 1'b0;
          state_d  = ST_IDLE;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    strobe_n_d = !bus_active(state_d);
    busy_d     = bus_active(state_d);
  end

  assign addr_out    = addr_q;
  assign mreq_n      = strobe_n_q;
  assign rd_n        = strobe_n_q;
  assign reg_mem_din = din_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// tb_mem_rd_ctrl
// Directed bench for mem_rd_ctrl. Each read is run for a fixed number of
// cycles; outputs are sampled on the falling edge into per-cycle arrays and
// then checked against hand-computed values.
module tb_mem_rd_ctrl;

  logic        clk;
  logic        reset;
  logic        rd_start;
  logic        rd_word;
  logic [15:0] rd_addr;
  logic        wait_n;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic        mreq_n;
  logic        rd_n;
  logic [15:0] reg_mem_din;
  logic        busy;
  logic        done;

  logic        scramble;
  int          n_chk;
  int          n_fail;

  logic [15:0] s_addr [0:15];
  logic [15:0] s_din  [0:15];
  logic        s_mreq [0:15];
  logic        s_rdn  [0:15];
  logic        s_busy [0:15];
  logic        s_done [0:15];

  mem_rd_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rd_start    (rd_start),
    .rd_word     (rd_word),
    .rd_addr     (rd_addr),
    .wait_n      (wait_n),
    .data_in     (data_in),
    .addr_out    (addr_out),
    .mreq_n      (mreq_n),
    .rd_n        (rd_n),
    .reg_mem_din (reg_mem_din),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small memory image; scramble inverts the bus so an early capture shows up.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h2000: return 8'h34;
      16'h2001: return 8'h12;
      16'h1234: return 8'hA5;
      16'hFFFF: return 8'h5A;
      16'h0000: return 8'hC3;
      default:  return ~a[7:0];
    endcase
  endfunction

  assign data_in = mem_byte(addr_out) ^ (scramble ? 8'hFF : 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 drives rd_start; cycles 1..ncyc are sampled, then masks for that
  // cycle are applied (they are seen by the edge ending the cycle).
  task automatic do_read(input logic [15:0] a, input logic w, input int ncyc,
                         input logic [15:0] wait_m, input logic [15:0] scr_m,
                         input logic [15:0] start_m, input logic [15:0] rst_m);
    @(negedge clk);
    rd_addr  = a;
    rd_word  = w;
    rd_start = 1'b1;
    wait_n   = 1'b1;
    scramble = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      s_addr[i] = addr_out;
      s_din[i]  = reg_mem_din;
      s_mreq[i] = mreq_n;
      s_rdn[i]  = rd_n;
      s_busy[i] = busy;
      s_done[i] = done;
      rd_start  = start_m[i];
      wait_n    = !wait_m[i];
      scramble  = scr_m[i];
      reset     = rst_m[i];
    end
    rd_start = 1'b0;
    wait_n   = 1'b1;
    scramble = 1'b0;
    reset    = 1'b0;
  endtask

  function automatic int cnt_low(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (!s_mreq[i] && !s_rdn[i]) n++;
    return n;
  endfunction

  function automatic int cnt_done(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (s_done[i]) n++;
    return n;
  endfunction

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rd_start = 1'b0;
    rd_word  = 1'b0;
    rd_addr  = 16'h0;
    wait_n   = 1'b1;
    scramble = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mreq_n", mreq_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_addr", addr_out, 16'h0000);
    chk("rst_din", reg_mem_din, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Word read at 0x2000: bytes 0x34 then 0x12, done at k+7.
    do_read(16'h2000, 1'b1, 8, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("word_addr_t1", s_addr[1], 16'h2000);
    chk("word_busy_t1", s_busy[1], 1);
    chk("word_addr_t3", s_addr[3], 16'h2000);
    chk("word_addr_2nd", s_addr[4], 16'h2001);
    chk("word_lo_early", s_din[4], 16'h0034);
    chk("word_low_cnt", cnt_low(1, 6), 6);
    chk("word_strobe_end", s_mreq[7], 1);
    chk("word_done_k7", s_done[7], 1);
    chk("word_done_cnt", cnt_done(1, 8), 1);
    chk("word_din", s_din[7], 16'h1234);
    chk("word_busy_k6", s_busy[6], 1);
    chk("word_busy_done", s_busy[7], 0);

    // Byte read at 0x1234: upper byte must keep 0x12.
    do_read(16'h1234, 1'b0, 5, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("byte_addr_t1", s_addr[1], 16'h1234);
    chk("byte_addr_t3", s_addr[3], 16'h1234);
    chk("byte_low_cnt", cnt_low(1, 5), 3);
    chk("byte_done_k3", s_done[3], 0);
    chk("byte_done_k4", s_done[4], 1);
    chk("byte_din", s_din[4], 16'h12A5);
    chk("byte_rd_n_idle", s_rdn[4], 1);

    // Byte read with wait_n low through T2 and the first TW; bus inverted
    // until T3, so only a capture at the end of T3 gives 0xAA.
    do_read(16'h3055, 1'b0, 7, 16'h000C, 16'h001C, 16'h0, 16'h0);
    chk("wait_low_cnt", cnt_low(1, 7), 5);
    chk("wait_done_k5", s_done[5], 0);
    chk("wait_done_k6", s_done[6], 1);
    chk("wait_din", s_din[6], 16'h12AA);

    // Word read at 0xFFFF wraps to 0x0000.
    do_read(16'hFFFF, 1'b1, 8, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("wrap_addr_1st", s_addr[1], 16'hFFFF);
    chk("wrap_addr_2nd", s_addr[4], 16'h0000);
    chk("wrap_done_k7", s_done[7], 1);
    chk("wrap_din", s_din[7], 16'hC35A);

    // rd_start during T2 is ignored.
    do_read(16'h1234, 1'b0, 8, 16'h0, 16'h0, 16'h0004, 16'h0);
    chk("ign_done_cnt", cnt_done(1, 8), 1);
    chk("ign_idle_k5", s_mreq[5], 1);
    chk("ign_din", s_din[4], 16'hC3A5);

    // rd_start held in the done cycle starts a back-to-back read.
    do_read(16'h2000, 1'b0, 9, 16'h0, 16'h0, 16'h0010, 16'h0);
    chk("b2b_done_k4", s_done[4], 1);
    chk("b2b_t1_mreq", s_mreq[5], 0);
    chk("b2b_t1_busy", s_busy[5], 1);
    chk("b2b_t1_addr", s_addr[5], 16'h2000);
    chk("b2b_done_k8", s_done[8], 1);
    chk("b2b_done_cnt", cnt_done(1, 9), 2);
    chk("b2b_din", s_din[8], 16'hC334);

    // Reset asserted during the second T2 of a word read.
    do_read(16'h4000, 1'b1, 8, 16'h0, 16'h0, 16'h0, 16'h0020);
    chk("rmid_addr_2nd", s_addr[5], 16'h4001);
    chk("rmid_mreq", s_mreq[6], 1);
    chk("rmid_rd_n", s_rdn[6], 1);
    chk("rmid_busy", s_busy[6], 0);
    chk("rmid_din", s_din[6], 16'h0000);
    chk("rmid_addr", s_addr[6], 16'h0000);
    chk("rmid_done_cnt", cnt_done(1, 8), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rd_ctrl.md
# mem_rd_ctrl

Memory-read sequencer for the Z80 core: the inbound counterpart of the memory data-out path. On a request from the control unit it runs Z80-style read machine cycles (T1, T2, optional TW wait states, T3) on the external bus. It drives address, `mreq_n` and `rd_n`, and captures the data bus into `reg_mem_din`, one byte or a little-endian 16-bit word. It sits between the control FSM / address muxes and the external memory pins.

## Interface
Parameters: none (widths fixed by the Z80 bus).

- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `rd_start`  in  1  request strobe; sampled only in IDLE
- `rd_word`  in  1  1 = two-byte read (lo @addr, hi @addr+1), 0 = single byte; sampled with `rd_start`
- `rd_addr`  in  16  start address; sampled with `rd_start`
- `wait_n`  in  1  memory wait request, active low
- `data_in`  in  8  external data bus
- `addr_out`  out  16  external address bus (registered)
- `mreq_n`  out  1  memory request, active low (registered)
- `rd_n`  out  1  read strobe, active low (registered)
- `reg_mem_din`  out  16  captured read data; [7:0] = first byte, [15:8] = second byte
- `busy`  out  1  high from the cycle after acceptance until `done`
- `done`  out  1  one-cycle pulse: `reg_mem_din` valid

## Operation
- States: IDLE, T1, T2, TW, T3. Internal flags: `word_q` (latched `rd_word`) and `second_q` (second byte in progress).
- IDLE: `rd_start`=1 -> latch `rd_addr` into `addr_out`, latch `word_q`, clear `second_q`, go T1. `rd_start` outside IDLE is ignored, with no queuing.
- T1: `mreq_n`=0, `rd_n`=0, `addr_out` stable -> T2.
- T2: `wait_n`=0 at the edge ending T2 -> TW; otherwise -> T3.
- TW: repeats while `wait_n`=0; `wait_n`=1 -> T3. Strobes stay low.
- T3: on the edge ending T3, `data_in` -> `reg_mem_din[7:0]` if `second_q`=0, else `reg_mem_din[15:8]`.
  - If `word_q`=1 and `second_q`=0: `addr_out` <= `addr_out`+1 (16-bit modulo, so 0xFFFF wraps to 0x0000), set `second_q`, go T1.
  - Otherwise: go IDLE and assert `done` for one cycle.
- `mreq_n`/`rd_n` are low exactly in T1, T2, TW and T3; high in IDLE. Between the two bytes of a word the strobes go high for zero cycles: the T3->T1 transition keeps them low.
- Byte read leaves `reg_mem_din[15:8]` unchanged.
- `reg_mem_din` holds its value until the next capture.
- `addr_out` holds its last value in IDLE.
- Simultaneous `done` and `rd_start`: the new request is accepted because the state is IDLE that cycle.
- Reset (including mid-cycle): state IDLE, `mreq_n`=`rd_n`=1, `addr_out`=0, `reg_mem_din`=0, `busy`=0, `done`=0, flags cleared. There is no partial capture.

## Timing
- `rd_start` sampled at edge k: T1 in cycle k+1, T2 in k+2, T3 in k+3.
- Byte read with no waits: `done`=1 and data valid in cycle k+4.
- Word read with no waits: second T1 in k+4; `done` in k+7.
- Each TW adds exactly one cycle per byte.
- `busy`=1 in cycles k+1 up to and including the cycle before `done`; `busy`=0 while `done`=1.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Structure
- State encoding and `MEM_RD_STATE_WIDTH` go in the shared `buswidth.vh` alongside the other bus-width constants.
- Single flat module with one FSM `always` block plus output registers; no sub-module.

## Test plan
- Byte read: `rd_addr`=0x1234, `rd_word`=0, `data_in`=0xA5 in T3, `wait_n`=1.
  - `addr_out`=0x1234 during T1–T3.
  - Strobes low for 3 cycles.
  - `done` at k+4 with `reg_mem_din[7:0]`=0xA5; [15:8] keeps its prior value.
- Word read: `rd_addr`=0x2000, bytes 0x34 then 0x12.
  - `addr_out` 0x2000 then 0x2001.
  - `reg_mem_din`=0x1234, `done` at k+7.
  - Strobes continuously low for 6 cycles.
- Wait states: byte read with `wait_n`=0 for 2 cycles from T2 -> two TW cycles, `done` at k+6, data captured only at the end of T3.
- Wrap: word read at 0xFFFF -> second byte from 0x0000; `reg_mem_din`={byte@0x0000, byte@0xFFFF}.
- Request handling: `rd_start` pulsed during T2 -> ignored, exactly one `done`. `rd_start` held in the `done` cycle -> back-to-back read, T1 begins in the next cycle.
- Reset mid-word (in second T2): next cycle `mreq_n`=`rd_n`=1, `busy`=0, `reg_mem_din`=0x0000, no `done` pulse.
